adder_acc: RTL
==============

// Module: adder_acc
// PURPOSE
//   Parametrised, registered add/subtract/accumulate unit. This is the next generation of
//   the team's combinational 4-bit adder. It accepts operand pairs over a valid/ready
//   handshake and returns a registered result with carry and signed-overflow flags.
//   It keeps a running accumulator. It sits between an operand source and a result
//   consumer, and the consumer may apply backpressure.
// PARAMETERS
//   WIDTH     4   operand, result and accumulator width (>=2)
//   SATURATE  0   1 = clamp signed result on overflow; 0 = two's-complement wrap
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous reset, active low
//   in_valid   in   1      operands/op present
//   in_ready   out  1      unit can accept this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B (ignored for ACC/CLR)
//   op         in   2      00 ADD, 01 SUB, 10 ACC, 11 CLR
//   out_valid  out  1      result registers hold an unconsumed result
//   out_ready  in   1      consumer takes result this cycle
//   c          out  WIDTH  result
//   carry      out  1      ADD/ACC: carry out; SUB: borrow (a<b unsigned)
//   ovf        out  1      signed overflow of this result
//   acc        out  WIDTH  current accumulator value
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): out_valid=0, c=0, carry=0, ovf=0, acc=0. Inputs ignored.
//     Reset mid-operation drops any pending result.
//   - One-entry output stage. States: EMPTY (out_valid=0) and FULL (out_valid=1).
//   - in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
//   - Latency 1: on an accepting edge, c/carry/ovf load and out_valid=1 from the next cycle.
//   - EMPTY->FULL on accept. FULL->EMPTY on drain (out_valid && out_ready) without accept.
//     Drain and accept on the same edge: stay FULL with the new result, with no bubble.
//   - While FULL and !out_ready, c/carry/ovf/out_valid hold stable and in_ready=0.
//   - Arithmetic is computed WIDTH+1 bits wide:
//     ADD {carry,c}=a+b
//     SUB c=a+~b+1, carry=(a<b)
//     ACC {carry,s}=acc+a, acc<=s, c=s
//     CLR acc<=0, c=0, carry=0, ovf=0
//   - ovf=1 when both addends (a,~b for SUB; acc,a for ACC) share a sign and the result
//     sign differs.
//   - SATURATE=1 and ovf: c (and acc for ACC) = 0111..1 if the true result is positive,
//     1000..0 if negative. carry and ovf are reported unchanged.
//   - acc changes only on accepted ACC/CLR. ADD/SUB never modify it.
//     acc output is registered and updates on the accept edge.
// TESTING (WIDTH=4)
//   1. rst_n=0 for 2 cycles with in_valid=1, op=ADD
//      -> out_valid=0, acc=0, no accept; in_ready=1 after release.
//   2. ADD a=7,b=1 -> c=8, carry=0, ovf=1 (SATURATE=1: c=7).
//      ADD a=15,b=1 -> c=0, carry=1, ovf=0.
//   3. SUB a=3,b=5 -> c=14, carry=1, ovf=0.
//      SUB a=8,b=1 -> c=7, carry=0, ovf=1 (SATURATE=1: c=8).
//   4. ACC a=3,3,3 -> acc=3,6,9, ovf on third; ACC a=7 -> acc=0, carry=1; CLR -> acc=0, c=0.
//   5. ADD 2+3 with out_ready=0 for 3 cycles -> c=5 held, in_ready=0, new operands not taken.
//      Then out_ready=1 with in_valid=1 (ADD 4+4) -> c=8 next cycle, out_valid stays 1.
//   6. out_valid=1, acc=9, assert rst_n=0 one cycle -> out_valid=0, acc=0, c=0 next cycle.

Source files
------------

// File: rtl/adder_acc_if.sv
// Operand/result handshake bundle for adder_acc: valid/ready in, valid/ready out,
// plus the flags and the live accumulator value.
interface adder_acc_if #(
   parameter int unsigned WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] c;
   logic             carry;
   logic             ovf;
   logic [WIDTH-1:0] acc;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, c, carry, ovf, acc
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, c, carry, ovf, acc
   );
endinterface

// File: rtl/adder_acc.sv
// Registered add/subtract/accumulate unit with a one-entry output stage,
// carry/borrow and signed-overflow flags, and optional signed saturation.
module adder_acc #(
   parameter int unsigned WIDTH    = 4,
   parameter bit          SATURATE = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   adder_acc_if.slave  bus
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ACC = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             out_valid;
   logic             in_ready;
   logic             accept;
   logic             drain;

   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             cin;
   logic [WIDTH:0]   sum_w;
   logic             ovf_raw;
   logic [WIDTH-1:0] res;

   assign out_valid = (state_q == FULL);
   assign in_ready  = !out_valid || bus.out_ready;
   assign accept    = bus.in_valid && in_ready;
   assign drain     = out_valid && bus.out_ready;

   // SUB reuses the adder as a + ~b + 1; the borrow flag is taken from a direct
   // unsigned compare rather than the inverted adder carry.
   always_comb begin
      opa = '0;
      opb = '0;
      cin = 1'b0;
      case (bus.op)
         OP_ADD: begin
            opa = bus.a;
            opb = bus.b;
         end
         OP_SUB: begin
            opa = bus.a;
            opb = ~bus.b;
            cin = 1'b1;
         end
         OP_ACC: begin
            opa = acc_q;
            opb = bus.a;
         end
         default: begin
            opa = '0;
            opb = '0;
         end
      endcase
      sum_w   = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
      ovf_raw = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum_w[WIDTH-1] != opa[WIDTH-1]);
      // Both addends share a sign on overflow, so that sign gives the true result's sign.
      if (SATURATE && ovf_raw) begin
         res = opa[WIDTH-1] ? SAT_NEG : SAT_POS;
      end else begin
         res = sum_w[WIDTH-1:0];
      end
   end

   always_comb begin
      c_d     = c_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      acc_d   = acc_q;
      if (accept) begin
         case (bus.op)
            OP_ADD: begin
               c_d     = res;
               carry_d = sum_w[WIDTH];
               ovf_d   = ovf_raw;
            end
            OP_SUB: begin
               c_d     = res;
               carry_d = (bus.a < bus.b);
               ovf_d   = ovf_raw;
            end
            OP_ACC: begin
               c_d     = res;
               carry_d = sum_w[WIDTH];
               ovf_d   = ovf_raw;
               acc_d   = res;
            end
            default: begin
               c_d     = '0;
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               acc_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = FULL;
      end else if (drain) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         c_q     <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         acc_q   <= acc_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.c         = c_q;
   assign bus.carry     = carry_q;
   assign bus.ovf       = ovf_q;
   assign bus.acc       = acc_q;

endmodule
